// File: rtl/sevseg_pkg.sv
// Shared segment constants and the nibble-to-segment decode for sev_segment_mux.
// Patterns are active-low cathodes, bit6 = a ... bit0 = g.
package sevseg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // In decimal mode anything above 9 is not a valid BCD digit, so show a dash.
   function automatic logic [6:0] nib2seg(input logic [3:0] nib, input logic hex);
      logic [6:0] s;
      case (nib)
         4'h0:    s = SEG_0;
         4'h1:    s = SEG_1;
         4'h2:    s = SEG_2;
         4'h3:    s = SEG_3;
         4'h4:    s = SEG_4;
         4'h5:    s = SEG_5;
         4'h6:    s = SEG_6;
         4'h7:    s = SEG_7;
         4'h8:    s = SEG_8;
         4'h9:    s = SEG_9;
         4'hA:    s = hex ? SEG_A : SEG_DASH;
         4'hB:    s = hex ? SEG_B : SEG_DASH;
         4'hC:    s = hex ? SEG_C : SEG_DASH;
         4'hD:    s = hex ? SEG_D : SEG_DASH;
         4'hE:    s = hex ? SEG_E : SEG_DASH;
         default: s = hex ? SEG_F : SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sev_segment_mux_if.sv
// Load-side bus of sev_segment_mux: digit data, mode bits, load strobe and ack.
// Optional SEVSEG_BLINK_EN adds the per-digit blink mask.
interface sev_segment_mux_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] digits_in;
   logic [DIGITS-1:0]   dp_in;
   logic                load;
   logic                load_ack;
   logic                hex_mode;
   logic                blank_lz;
`ifdef SEVSEG_BLINK_EN
   logic [DIGITS-1:0]   blink_mask;

   modport master (output digits_in, dp_in, load, hex_mode, blank_lz, blink_mask, input load_ack);
   modport slave  (input digits_in, dp_in, load, hex_mode, blank_lz, blink_mask, output load_ack);
`else
   modport master (output digits_in, dp_in, load, hex_mode, blank_lz, input load_ack);
   modport slave  (input digits_in, dp_in, load, hex_mode, blank_lz, output load_ack);
`endif
endinterface

// File: rtl/sevseg_decoder.sv
// Combinational nibble + mode to seven-segment pattern for the selected digit.
module sevseg_decoder
   import sevseg_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       hex_mode,
   output logic [6:0] seg
);
   assign seg = nib2seg(nib, hex_mode);
endmodule

// File: rtl/sev_segment_mux.sv
// N-digit multiplexed seven-segment driver: scan prescaler, PWM dimming,
// shadow/display double buffer with frame-aligned transfer, leading-zero blanking.
// Optional blink feature enabled by defining SEVSEG_BLINK_EN.
module sev_segment_mux
   import sevseg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 100000
`ifdef SEVSEG_BLINK_EN
   , parameter int BLINK_FRAMES = 64
`endif
) (
   input  logic                clk,
   input  logic                rst,
   sev_segment_mux_if.slave    bus,
   input  logic [3:0]          brightness,
   output logic [DIGITS-1:0]   active_anode,
   output logic [6:0]          seg,
   output logic                dp
);
   localparam int PW = $clog2(PRESCALE);
   localparam int SW = $clog2(DIGITS);

   logic [PW-1:0]       presc_q, presc_d;
   logic [SW-1:0]       sel_q, sel_d;
   logic [3:0]          pwm_q, pwm_d;
   logic [4*DIGITS-1:0] sh_dig_q, sh_dig_d, disp_dig_q, disp_dig_d;
   logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
   logic                sh_hex_q, sh_hex_d, disp_hex_q, disp_hex_d;
   logic                sh_blz_q, sh_blz_d, disp_blz_q, disp_blz_d;
   logic                pend_q, pend_d, ack_q, ack_d;
   logic [DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic                tc, wrap, lit, zero_run, cur_dp, cur_lz, cur_blk;
   logic [DIGITS-1:0]   lz;
   logic [3:0]          cur_nib;
   logic [6:0]          dec_seg;
`ifdef SEVSEG_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   logic [DIGITS-1:0]   sh_blk_q, sh_blk_d, disp_blk_q, disp_blk_d;
   logic [FW-1:0]       frm_q, frm_d;
   logic                phase_q, phase_d;
`endif

   // Slot timing: prescaler, digit select and PWM phase (PWM restarts each slot).
   always_comb begin
      tc      = (presc_q == PW'(PRESCALE - 1));
      wrap    = tc && (sel_q == SW'(DIGITS - 1));
      presc_d = presc_q + 1'b1;
      pwm_d   = pwm_q + 4'd1;
      sel_d   = sel_q;
      if (tc) begin
         presc_d = '0;
         pwm_d   = '0;
         sel_d   = wrap ? '0 : sel_q + 1'b1;
      end
   end

   // Shadow capture and frame-aligned transfer; a load in the transfer cycle
   // is kept pending for the next frame while the old shadow goes out now.
   always_comb begin
      sh_dig_d   = sh_dig_q;
      sh_dp_d    = sh_dp_q;
      sh_hex_d   = sh_hex_q;
      sh_blz_d   = sh_blz_q;
      disp_dig_d = disp_dig_q;
      disp_dp_d  = disp_dp_q;
      disp_hex_d = disp_hex_q;
      disp_blz_d = disp_blz_q;
      pend_d     = pend_q;
      ack_d      = wrap && pend_q;
`ifdef SEVSEG_BLINK_EN
      sh_blk_d   = sh_blk_q;
      disp_blk_d = disp_blk_q;
`endif
      if (ack_d) begin
         disp_dig_d = sh_dig_q;
         disp_dp_d  = sh_dp_q;
         disp_hex_d = sh_hex_q;
         disp_blz_d = sh_blz_q;
`ifdef SEVSEG_BLINK_EN
         disp_blk_d = sh_blk_q;
`endif
         pend_d     = 1'b0;
      end
      if (bus.load) begin
         sh_dig_d = bus.digits_in;
         sh_dp_d  = bus.dp_in;
         sh_hex_d = bus.hex_mode;
         sh_blz_d = bus.blank_lz;
`ifdef SEVSEG_BLINK_EN
         sh_blk_d = bus.blink_mask;
`endif
         pend_d   = 1'b1;
      end
   end

`ifdef SEVSEG_BLINK_EN
   // Blink phase toggles once every BLINK_FRAMES completed frames.
   always_comb begin
      frm_d   = frm_q;
      phase_d = phase_q;
      if (wrap) begin
         if (frm_q == FW'(BLINK_FRAMES - 1)) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
   end
`endif

   // Leading-zero map and mux of the selected digit's data.
   always_comb begin
      zero_run = 1'b1;
      lz       = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_dig_q[4*i +: 4] == 4'h0);
         lz[i]    = zero_run && (i > 0) && disp_blz_q;
      end
      cur_nib = '0;
      cur_dp  = 1'b0;
      cur_lz  = 1'b0;
      cur_blk = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (sel_q == SW'(i)) begin
            cur_nib = disp_dig_q[4*i +: 4];
            cur_dp  = disp_dp_q[i];
            cur_lz  = lz[i];
`ifdef SEVSEG_BLINK_EN
            cur_blk = disp_blk_q[i] && phase_q;
`endif
         end
      end
   end

   sevseg_decoder u_dec (
      .nib      (cur_nib),
      .hex_mode (disp_hex_q),
      .seg      (dec_seg)
   );

   // Pin values for the current slot; dark PWM phases blank everything.
   always_comb begin
      lit     = (brightness == 4'hF) || (pwm_q < brightness);
      anode_d = '1;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      if (lit) begin
         for (int i = 0; i < DIGITS; i++)
            if (sel_q == SW'(i)) anode_d[i] = 1'b0;
         seg_d = cur_lz ? SEG_BLANK : dec_seg;
         dp_d  = ~cur_dp;
         if (cur_blk) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
         end
      end
   end

   // All state and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_q    <= '0;
         sel_q      <= '0;
         pwm_q      <= '0;
         sh_dig_q   <= '0;
         sh_dp_q    <= '0;
         sh_hex_q   <= 1'b0;
         sh_blz_q   <= 1'b0;
         disp_dig_q <= '0;
         disp_dp_q  <= '0;
         disp_hex_q <= 1'b0;
         disp_blz_q <= 1'b0;
         pend_q     <= 1'b0;
         ack_q      <= 1'b0;
         anode_q    <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
`ifdef SEVSEG_BLINK_EN
         sh_blk_q   <= '0;
         disp_blk_q <= '0;
         frm_q      <= '0;
         phase_q    <= 1'b0;
`endif
      end else begin
         presc_q    <= presc_d;
         sel_q      <= sel_d;
         pwm_q      <= pwm_d;
         sh_dig_q   <= sh_dig_d;
         sh_dp_q    <= sh_dp_d;
         sh_hex_q   <= sh_hex_d;
         sh_blz_q   <= sh_blz_d;
         disp_dig_q <= disp_dig_d;
         disp_dp_q  <= disp_dp_d;
         disp_hex_q <= disp_hex_d;
         disp_blz_q <= disp_blz_d;
         pend_q     <= pend_d;
         ack_q      <= ack_d;
         anode_q    <= anode_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
`ifdef SEVSEG_BLINK_EN
         sh_blk_q   <= sh_blk_d;
         disp_blk_q <= disp_blk_d;
         frm_q      <= frm_d;
         phase_q    <= phase_d;
`endif
      end
   end

   assign active_anode = anode_q;
   assign seg          = seg_q;
   assign dp           = dp_q;
   assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_sev_segment_mux.sv
// Self-checking bench for sev_segment_mux: scoreboard of expected per-digit
// pin values, checked as the DUT scans each frame. A second instance with a
// longer slot covers PWM duty within a slot that spans two PWM periods.
module tb_sev_segment_mux;

   typedef struct {
      logic [3:0] an;
      logic [6:0] sg;
      logic       dp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] brightness;
   logic [3:0] active_anode, an32;
   logic [6:0] seg, seg32;
   logic       dp, dp32;

   int   n_checks = 0;
   int   n_errors = 0;
   int   ack_cnt  = 0;
   exp_t sb_q[$];

   logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   sev_segment_mux_if #(.DIGITS(4)) bus ();
   sev_segment_mux_if #(.DIGITS(4)) bus32 ();

   sev_segment_mux #(.DIGITS(4), .PRESCALE(16)) u_dut (
      .clk(clk), .rst(rst), .bus(bus), .brightness(brightness),
      .active_anode(active_anode), .seg(seg), .dp(dp));

   sev_segment_mux #(.DIGITS(4), .PRESCALE(32)) u_dut32 (
      .clk(clk), .rst(rst), .bus(bus32), .brightness(brightness),
      .active_anode(an32), .seg(seg32), .dp(dp32));

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.load_ack === 1'b1) ack_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] nib, input logic hx);
      if (!hx && nib > 4'd9) return 7'b1111110;
      return tbl[nib];
   endfunction

   // Expected pins for one frame of digit 0..3 at full brightness.
   task automatic push_frame(input logic [15:0] dg, input logic [3:0] dpv,
                             input logic hx, input logic blz);
      logic       z;
      logic [3:0] blanked;
      exp_t       e;
      z = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         z = z && (dg[4*i +: 4] == 4'h0);
         blanked[i] = blz && (i > 0) && z;
      end
      for (int i = 0; i < 4; i++) begin
         e.an = ~(4'b0001 << i);
         e.sg = blanked[i] ? 7'h7F : ref_seg(dg[4*i +: 4], hx);
         e.dp = ~dpv[i];
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_anode(input logic [3:0] pat, input string tag);
      int n = 0;
      @(negedge clk);
      while (active_anode !== pat && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk({tag, "_timeout"}, {28'd0, active_anode}, {28'd0, pat});
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      @(negedge clk);
      while (bus.load_ack !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk({tag, "_timeout"}, 32'(bus.load_ack), 32'd1);
   endtask

   task automatic drain_frame(input string tag);
      exp_t e;
      wait_anode(4'b1110, tag);
      for (int k = 0; k < 4; k++) begin
         e = sb_q.pop_front();
         chk($sformatf("%s_d%0d_an", tag, k), 32'(active_anode), 32'(e.an));
         chk($sformatf("%s_d%0d_seg", tag, k), 32'(seg), 32'(e.sg));
         chk($sformatf("%s_d%0d_dp", tag, k), 32'(dp), 32'(e.dp));
         if (k < 3) repeat (16) @(negedge clk);
      end
   endtask

   task automatic do_load(input logic [15:0] dg, input logic [3:0] dpv,
                          input logic hx, input logic blz);
      bus.digits_in = dg;
      bus.dp_in     = dpv;
      bus.hex_mode  = hx;
      bus.blank_lz  = blz;
      bus.load      = 1'b1;
      @(negedge clk);
      bus.load      = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_an"}, 32'(active_anode), 32'hF);
      chk({tag, "_seg"}, 32'(seg), 32'h7F);
      chk({tag, "_dp"}, 32'(dp), 32'd1);
      chk({tag, "_ack"}, 32'(bus.load_ack), 32'd0);
      chk({tag, "_an32"}, 32'(an32), 32'hF);
   endtask

   initial begin
      int base;
      int lo16 [4];
      int lo32 [4];
      int dark;
      brightness    = 4'hF;
      bus.digits_in = '0;
      bus.dp_in     = '0;
      bus.load      = 1'b0;
      bus.hex_mode  = 1'b0;
      bus.blank_lz  = 1'b0;
      bus32.digits_in = '0;
      bus32.dp_in     = '0;
      bus32.load      = 1'b0;
      bus32.hex_mode  = 1'b0;
      bus32.blank_lz  = 1'b0;
`ifdef SEVSEG_BLINK_EN
      bus.blink_mask   = '0;
      bus32.blink_mask = '0;
`endif
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b1;

      // Cleared display scans zeros on every digit.
      push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
      drain_frame("scan0");

      // Mid-frame load: old data stays until the wrap, then one ack.
      wait_anode(4'b1011, "t2_sel2");
      base = ack_cnt;
      do_load(16'h1234, 4'h0, 1'b0, 1'b0);
      wait_anode(4'b0111, "t2_sel3");
      chk("t2_old_d3", 32'(seg), 32'(ref_seg(4'h0, 1'b0)));
      wait_ack("t2_ack");
      push_frame(16'h1234, 4'h0, 1'b0, 1'b0);
      drain_frame("t2");
      chk("t2_ack_cnt", 32'(ack_cnt - base), 32'd1);

      // Decimal vs hex decode of A/F.
      do_load(16'h00AF, 4'h0, 1'b0, 1'b0);
      wait_ack("t3a_ack");
      push_frame(16'h00AF, 4'h0, 1'b0, 1'b0);
      drain_frame("t3dec");
      do_load(16'h00AF, 4'h0, 1'b1, 1'b0);
      wait_ack("t3b_ack");
      push_frame(16'h00AF, 4'h0, 1'b1, 1'b0);
      drain_frame("t3hex");

      // Leading-zero blanking with a decimal point on a blanked digit.
      do_load(16'h0050, 4'b1000, 1'b0, 1'b1);
      wait_ack("t4_ack");
      push_frame(16'h0050, 4'b1000, 1'b0, 1'b1);
      drain_frame("t4lz");

      // PWM duty: brightness 4 lights 4 of every 16 cycles.
      brightness = 4'd4;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         lo16[i] = 0;
         lo32[i] = 0;
      end
      for (int c = 0; c < 128; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (!active_anode[i]) lo16[i]++;
            if (!an32[i]) lo32[i]++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pwm4_p16_d%0d", i), 32'(lo16[i]), 32'd8);
         chk($sformatf("pwm4_p32_d%0d", i), 32'(lo32[i]), 32'd8);
      end
      brightness = 4'd0;
      repeat (4) @(negedge clk);
      dark = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (active_anode != 4'hF || seg != 7'h7F || dp != 1'b1 || an32 != 4'hF) dark++;
      end
      chk("pwm0_dark", 32'(dark), 32'd0);
      brightness = 4'hF;

      // Load landing on the transfer cycle: old shadow goes out, new one waits.
      wait_anode(4'b1101, "t6_sel1");
      do_load(16'h5678, 4'h0, 1'b0, 1'b0);
      wait_anode(4'b0111, "t6_sel3");
      repeat (14) @(negedge clk);
      do_load(16'h9A0C, 4'b0001, 1'b1, 1'b0);
      chk("t6_coinc_ack", 32'(bus.load_ack), 32'd1);
      push_frame(16'h5678, 4'h0, 1'b0, 1'b0);
      drain_frame("t6a");
      wait_ack("t6b_ack");
      push_frame(16'h9A0C, 4'b0001, 1'b1, 1'b0);
      drain_frame("t6b");

      // Two loads before one wrap: single ack, last data wins.
      wait_anode(4'b1110, "t7_sel0");
      base = ack_cnt;
      do_load(16'h1111, 4'h0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      do_load(16'h2222, 4'h0, 1'b0, 1'b0);
      wait_ack("t7_ack");
      push_frame(16'h2222, 4'h0, 1'b0, 1'b0);
      drain_frame("t7");
      chk("t7_ack_cnt", 32'(ack_cnt - base), 32'd1);

      // Reset mid-frame discards a pending load.
      wait_anode(4'b1011, "t8_sel2");
      do_load(16'h3333, 4'hF, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset("midrst");
      repeat (2) @(negedge clk);
      rst  = 1'b1;
      base = ack_cnt;
      push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
      drain_frame("t8");
      repeat (80) @(negedge clk);
      chk("t8_no_ack", 32'(ack_cnt - base), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
